// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared FSM state and owner encodings for the memory port arbiter
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_ACC = 2'd1,
        DBG_ACC = 2'd2,
        RD_WAIT = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// rtl/mem_port_arbiter_arb_pick.sv - combinational winner select (MEM_ARB_ROUND_ROBIN_EN selects round-robin contention)
module arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic   cpu_req,
    input  logic   dbg_req,
    input  owner_e last_owner,
    input  logic   dbg_lock,
    output logic   pick_valid,
    output owner_e pick_owner
);

    logic lock_hold;

    // The loader only holds the port once it has actually won it.
    assign lock_hold = dbg_lock && (last_owner == OWN_DBG);

    // Pick at most one requester for the next access.
    always_comb begin
        pick_valid = 1'b0;
        pick_owner = OWN_CPU;
        if (lock_hold) begin
            pick_valid = dbg_req;
            pick_owner = OWN_DBG;
        end else if (cpu_req && dbg_req) begin
            pick_valid = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            pick_owner = (last_owner == OWN_CPU) ? OWN_DBG : OWN_CPU;
`else
            pick_owner = OWN_CPU;
`endif
        end else if (cpu_req) begin
            pick_valid = 1'b1;
            pick_owner = OWN_CPU;
        end else if (dbg_req) begin
            pick_valid = 1'b1;
            pick_owner = OWN_DBG;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - CPU/debug arbiter for one BRAM port (MEM_ARB_ROUND_ROBIN_EN enables round-robin contention)
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_lock,
    output logic              cpu_gnt,
    output logic              dbg_gnt,
    output logic              cpu_rvalid,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q
);

    arb_state_e        state_q, state_d;
    owner_e            last_owner_q, last_owner_d;
    logic              cpu_gnt_q, cpu_gnt_d;
    logic              dbg_gnt_q, dbg_gnt_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic              dbg_rvalid_q, dbg_rvalid_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              mem_we_q, mem_we_d;
    logic              pick_valid;
    owner_e            pick_owner;

    arb_pick u_arb_pick (
        .cpu_req    (cpu_req),
        .dbg_req    (dbg_req),
        .last_owner (last_owner_q),
        .dbg_lock   (dbg_lock),
        .pick_valid (pick_valid),
        .pick_owner (pick_owner)
    );

    // Next-state and registered-output computation for the access FSM.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        cpu_gnt_d    = 1'b0;
        dbg_gnt_d    = 1'b0;
        cpu_rvalid_d = 1'b0;
        dbg_rvalid_d = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = '0;
        mem_we_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    last_owner_d = pick_owner;
                    if (pick_owner == OWN_CPU) begin
                        state_d    = CPU_ACC;
                        cpu_gnt_d  = 1'b1;
                        mem_addr_d = cpu_addr;
                        mem_data_d = cpu_wdata;
                        mem_we_d   = cpu_we;
                    end else begin
                        state_d    = DBG_ACC;
                        dbg_gnt_d  = 1'b1;
                        mem_addr_d = dbg_addr;
                        mem_data_d = dbg_wdata;
                        mem_we_d   = dbg_we;
                    end
                end
            end
            CPU_ACC, DBG_ACC: begin
                if (mem_we_q) begin
                    state_d = IDLE;
                end else begin
                    // rvalid is raised for the cycle in which mem_q carries the read word.
                    state_d      = RD_WAIT;
                    cpu_rvalid_d = (state_q == CPU_ACC);
                    dbg_rvalid_d = (state_q == DBG_ACC);
                end
            end
            RD_WAIT: begin
                state_d = IDLE;
                if (cpu_rvalid_q) cpu_rdata_d = mem_q;
                if (dbg_rvalid_q) dbg_rdata_d = mem_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_owner_q <= OWN_CPU;
            cpu_gnt_q    <= 1'b0;
            dbg_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_we_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            cpu_gnt_q    <= cpu_gnt_d;
            dbg_gnt_q    <= dbg_gnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_we_q     <= mem_we_d;
        end
    end

    // Pulses are masked by rst so an aborted access never writes or returns data.
    assign cpu_gnt    = cpu_gnt_q & ~rst;
    assign dbg_gnt    = dbg_gnt_q & ~rst;
    assign cpu_rvalid = cpu_rvalid_q & ~rst;
    assign dbg_rvalid = dbg_rvalid_q & ~rst;
    assign mem_we     = mem_we_q & ~rst;
    assign cpu_rdata  = cpu_rvalid ? mem_q : cpu_rdata_q;
    assign dbg_rdata  = dbg_rvalid ? mem_q : dbg_rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
    logic [9:0]  cpu_addr, dbg_addr;
    logic [15:0] cpu_wdata, dbg_wdata;
    logic        cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid;
    logic [15:0] cpu_rdata, dbg_rdata;
    logic [9:0]  mem_addr;
    logic [15:0] mem_data;
    logic        mem_we;
    logic [15:0] mem_q;

    int checks = 0;
    int failures = 0;

    logic [15:0] ram [0:1023];
    logic [15:0] exp_mem [0:1023];
    logic [9:0]  waddrs [$];
    bit          exp_last;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_data;
        mem_q <= ram[mem_addr];
    end

    mem_port_arbiter #(.ADDR_W(10), .DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_lock(dbg_lock),
        .cpu_gnt(cpu_gnt), .dbg_gnt(dbg_gnt), .cpu_rvalid(cpu_rvalid), .dbg_rvalid(dbg_rvalid),
        .cpu_rdata(cpu_rdata), .dbg_rdata(dbg_rdata),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_q(mem_q)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Policy from the rules: a locked loader keeps the port, otherwise fixed CPU priority or alternation.
    function automatic bit exp_winner(input bit last, input logic lock);
        if (lock && last) return 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        return !last;
`else
        return 1'b0;
`endif
    endfunction

    task automatic wait_gnt(input bit who, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(who ? dbg_gnt : cpu_gnt) && n < 8);
    endtask

    task automatic access(input bit who, input bit we, input logic [9:0] addr, input logic [15:0] wd);
        int n;
        if (who) begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        end
        wait_gnt(who, n);
        chk("gnt_latency", n, 1);
        chk("other_gnt_low", who ? cpu_gnt : dbg_gnt, 0);
        chk("acc_mem_addr", mem_addr, addr);
        chk("acc_mem_we", mem_we, we);
        if (we) chk("acc_mem_data", mem_data, wd);
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        exp_last = who;
        if (we) begin
            exp_mem[addr] = wd;
            waddrs.push_back(addr);
        end
        @(negedge clk);
        if (we) begin
            chk("post_wr_we", mem_we, 0);
            chk("post_wr_data", mem_data, 0);
            chk("post_wr_addr", mem_addr, addr);
        end else begin
            chk("rvalid", who ? dbg_rvalid : cpu_rvalid, 1);
            chk("other_rvalid", who ? cpu_rvalid : dbg_rvalid, 0);
            chk("rdata", who ? dbg_rdata : cpu_rdata, exp_mem[addr]);
            chk("rd_wait_mem_data", mem_data, 0);
            chk("rd_wait_mem_we", mem_we, 0);
            @(negedge clk);
            chk("rvalid_pulse", who ? dbg_rvalid : cpu_rvalid, 0);
            chk("rdata_hold", who ? dbg_rdata : cpu_rdata, exp_mem[addr]);
        end
    endtask

    // Both requesters held; request fields must already be set by the caller.
    task automatic contention(input int ngrants, input int unlock_at);
        int cyc, prev, ngnt, ndbg;
        bit pend_valid, pend_own, win, prev_we, we_w;
        cyc = 0; prev = -1; ngnt = 0; ndbg = 0;
        pend_valid = 0; pend_own = 0; prev_we = 0;
        cpu_req = 1'b1;
        dbg_req = 1'b1;
        while ((ngnt < ngrants || pend_valid) && cyc < 80) begin
            @(negedge clk);
            cyc++;
            chk("single_gnt", cpu_gnt & dbg_gnt, 0);
            chk("single_rvalid", cpu_rvalid & dbg_rvalid, 0);
            if (cpu_rvalid || dbg_rvalid) begin
                chk("c_rvalid_owner", dbg_rvalid, pend_own);
                chk("c_rdata", pend_own ? dbg_rdata : cpu_rdata,
                    pend_own ? exp_mem[dbg_addr] : exp_mem[cpu_addr]);
                pend_valid = 0;
            end
            if (cpu_gnt || dbg_gnt) begin
                win = exp_winner(exp_last, dbg_lock);
                we_w = win ? dbg_we : cpu_we;
                chk("grant_owner", dbg_gnt, win);
                if (prev >= 0) chk("grant_spacing", cyc - prev, prev_we ? 2 : 3);
                chk("c_mem_addr", mem_addr, win ? dbg_addr : cpu_addr);
                chk("c_mem_we", mem_we, we_w);
                if (we_w) begin
                    chk("c_mem_data", mem_data, win ? dbg_wdata : cpu_wdata);
                    exp_mem[win ? dbg_addr : cpu_addr] = win ? dbg_wdata : cpu_wdata;
                    waddrs.push_back(win ? dbg_addr : cpu_addr);
                end else begin
                    pend_valid = 1;
                    pend_own = win;
                end
                prev = cyc;
                prev_we = we_w;
                exp_last = win;
                ngnt++;
                if (win) ndbg++;
                if (unlock_at > 0 && ndbg == unlock_at) dbg_lock = 1'b0;
                if (ngnt == ngrants) begin
                    cpu_req = 1'b0;
                    dbg_req = 1'b0;
                end
            end
        end
        chk("contention_done", ngnt, ngrants);
        @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_gnt"}, {cpu_gnt, dbg_gnt}, 0);
        chk({tag, "_rvalid"}, {cpu_rvalid, dbg_rvalid}, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_data"}, mem_data, 0);
        chk({tag, "_cpu_rdata"}, cpu_rdata, 0);
        chk({tag, "_dbg_rdata"}, dbg_rdata, 0);
    endtask

    initial begin
        bit          who, we;
        logic [9:0]  a;
        logic [15:0] d;
        int          n;

        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; dbg_lock = 0;
        exp_last = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_zero_outputs("reset");

        // CPU read of a word the loader placed at 0x005.
        access(1'b1, 1'b1, 10'h005, 16'h1234);
        access(1'b0, 1'b0, 10'h005, 16'h0000);
        chk("cpu_read_0x005", cpu_rdata, 16'h1234);

        // Top-of-memory write by debug, read back by CPU.
        access(1'b1, 1'b1, 10'h3FF, 16'hBEEF);
        access(1'b0, 1'b0, 10'h3FF, 16'h0000);
        chk("cpu_read_0x3ff", cpu_rdata, 16'hBEEF);

        // Random single-requester traffic.
        for (int i = 0; i < 40; i++) begin
            who = 1'($urandom_range(0, 1));
            we  = 1'($urandom_range(0, 1));
            d   = 16'($urandom);
            if (we) a = ($urandom_range(0, 3) == 0) ? 10'h000 : 10'($urandom_range(0, 31));
            else    a = waddrs[$urandom_range(0, waddrs.size() - 1)];
            access(who, we, a, d);
        end

        // Contention, four read grants after debug was last owner.
        access(1'b1, 1'b1, 10'h010, 16'($urandom));
        cpu_we = 0; cpu_addr = 10'h005;
        dbg_we = 0; dbg_addr = 10'h3FF;
        contention(4, 0);

        // Locked loader keeps the port until dbg_lock drops.
        dbg_lock = 1'b1;
        access(1'b1, 1'b1, 10'h022, 16'($urandom));
        dbg_lock = 1'b1;
        cpu_we = 1; cpu_addr = 10'h020; cpu_wdata = 16'($urandom);
        dbg_we = 1; dbg_addr = 10'h021; dbg_wdata = 16'($urandom);
        contention(4, 3);
        chk("lock_released_cpu_last", {31'd0, exp_last}, 0);
        dbg_lock = 1'b0;
        access(1'b0, 1'b0, 10'h020, 16'h0000);

        // Reset during RD_WAIT of a CPU read aborts the read.
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h3FF;
        wait_gnt(1'b0, n);
        chk("rst_rd_gnt_latency", n, 1);
        cpu_req = 0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_rd_no_rvalid", cpu_rvalid, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_last = 0;
        check_zero_outputs("rst_rd");
        access(1'b0, 1'b0, 10'h3FF, 16'h0000);

        // Reset in a write ACC cycle must suppress the write.
        dbg_req = 1; dbg_we = 1; dbg_addr = 10'h005; dbg_wdata = ~exp_mem[10'h005];
        wait_gnt(1'b1, n);
        chk("rst_wr_gnt_latency", n, 1);
        dbg_req = 0;
        rst = 1'b1;
        #1;
        chk("rst_wr_mem_we", mem_we, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_last = 0;
        check_zero_outputs("rst_wr");
        access(1'b0, 1'b0, 10'h005, 16'h0000);

        // CPU request withdrawn while debug owns the port.
        dbg_req = 1; dbg_we = 0; dbg_addr = 10'h021;
        wait_gnt(1'b1, n);
        chk("wd_dbg_latency", n, 1);
        dbg_req = 0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 10'h030; cpu_wdata = 16'hDEAD;
        @(negedge clk);
        chk("wd_dbg_rvalid", dbg_rvalid, 1);
        chk("wd_dbg_rdata", dbg_rdata, exp_mem[10'h021]);
        cpu_req = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("wd_no_cpu_gnt", cpu_gnt, 0);
            chk("wd_no_mem_we", mem_we, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
